sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
Switch-conditioning stage that feeds the LED state machine its clean `sw` vector.
- Synchronises the raw, asynchronous, bouncing slide-switch inputs into the `clk` domain.
- Qualifies each new switch pattern: a pattern is accepted only after it has been stable for DB_CYCLES consecutive clocks.
- Outputs a registered debounced vector plus one-cycle change, rise and fall pulses.
- The downstream FSM connects `sw_db` straight to its `sw` input.

Parameters:
- WIDTH, 3: number of switch bits.
- DB_CYCLES, 1000000: consecutive stable clocks needed to accept a new pattern (10 ms at 100 MHz). Legal minimum is 2.
- CNT_W, $clog2(DB_CYCLES): width of the stability counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- sw  input  WIDTH  raw switch inputs, asynchronous to clk.
- sw_db  output  WIDTH  debounced switch vector, registered.
- sw_chg  output  1  one-cycle pulse, high in the cycle `sw_db` takes a new value.
- sw_rise  output  WIDTH  per-bit one-cycle pulse for a 0->1 transition of `sw_db`.
- sw_fall  output  WIDTH  per-bit one-cycle pulse for a 1->0 transition of `sw_db`.

Behaviour:
- Reset: asserting `rst` low clears, independent of clk, the following:
  - sync stages s1 and s2, `cand`, `cnt`;
  - `sw_db`, `sw_chg`, `sw_rise`, `sw_fall` all go to 0;
  - state goes to STABLE.
  - Reset mid-settling discards the pending candidate. No pulse is emitted on entry to or exit from reset.
- Synchroniser: s1 <= sw, then s2 <= s1. Only s2 is used by the FSM. The whole vector is treated as one word.
- State machine, 2 states:
  - STABLE:
    - If s2 == sw_db, hold; cnt = 0.
    - If s2 != sw_db: cand <= s2, cnt <= 0, go to SETTLING.
  - SETTLING, priority in this order:
    1. If s2 == sw_db: go to STABLE, cnt <= 0. The glitch is discarded and no pulse is emitted.
    2. Else if s2 != cand: cand <= s2, cnt <= 0, stay in SETTLING. This restarts on a bounce or a different pattern.
    3. Else if cnt == DB_CYCLES-1: sw_db <= cand, sw_chg <= 1, sw_rise <= cand & ~sw_db, sw_fall <= ~cand & sw_db, go to STABLE.
    4. Else cnt <= cnt + 1.
- Pulses:
  - `sw_chg`, `sw_rise` and `sw_fall` are registered. They are high for exactly one clock, aligned with the `sw_db` update, and 0 otherwise.
  - Back-to-back commits are impossible: a minimum of DB_CYCLES+1 clocks separates them.
- Latency:
  - Let edge E1 be the first rising edge that samples the final settled `sw` value.
  - `sw_db` updates on edge E1 + DB_CYCLES + 2. With DB_CYCLES=4, that is the 7th edge counting E1 as the 1st.
  - Any change of s2 away from the candidate before the commit restarts the count.
- Width rules:
  - `cnt` saturates logically at DB_CYCLES-1 and never wraps, because the commit or an exit always occurs first.
  - All comparisons are full-vector equality.
- Multi-bit change: a simultaneous change of several bits is committed as one event, with the rise and fall bits set together.

Test Plan (DB_CYCLES=4):
1. Clean step: reset, `rst` released with sw=000, then sw=001 held.
   - Required: `sw_db`=001 on the 7th edge from E1, `sw_chg`=1 for one cycle, `sw_rise`=001, `sw_fall`=000.
2. Short glitch: from `sw_db`=000, sw=001 for 2 clocks, then back to 000.
   - Required: `sw_db` stays 000; `sw_chg`, `sw_rise` and `sw_fall` remain 0 throughout.
3. Bounce: from `sw_db`=001, sw alternates 011/001 each clock for 6 clocks, then holds 011.
   - Required: exactly one commit, `sw_db`=011 on the 7th edge after the first edge sampling the held 011; `sw_rise`=010.
4. Multi-bit step: from `sw_db`=011, sw=110 held.
   - Required: `sw_db`=110 after 7 edges, `sw_rise`=100, `sw_fall`=001, `sw_chg` one cycle.
5. Reset mid-settling: from `sw_db`=000, sw=111 held; assert `rst`=0 asynchronously, mid-clock, 2 edges after the SETTLING entry.
   - Required: all outputs 0 immediately with no clock edge, and no pulse.
   - After release with sw still 111: `sw_db`=111 on the 7th edge after the first post-release sampling edge.
6. Restart on a new pattern: from `sw_db`=000, sw=001 for 3 clocks, then 011 held.
   - Required: 001 is never committed; `sw_db`=011 on the 7th edge counting the first edge that samples 011; one `sw_chg` pulse.

Source files
------------

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchroniser and stability-qualified switch debouncer
// A new switch word is committed only after it has been seen unchanged for DB_CYCLES clocks.
module sw_debounce #(
  parameter int WIDTH     = 3,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db,
  output logic             sw_chg,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic             chg_q, chg_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_STABLE;
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      db_q    <= '0;
      chg_q   <= 1'b0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= sw;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      chg_q   <= chg_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    chg_d   = 1'b0;
    rise_d  = '0;
    fall_d  = '0;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (s2_q != db_q) begin
          cand_d  = s2_q;
          state_d = ST_SETTLING;
        end
      end
      ST_SETTLING: begin
        // Returning to the committed word wins over everything: the excursion was a glitch.
        if (s2_q == db_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (s2_q != cand_q) begin
          cand_d = s2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          db_d    = cand_q;
          chg_d   = 1'b1;
          rise_d  = cand_q & ~db_q;
          fall_d  = ~cand_q & db_q;
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sw_db   = db_q;
  assign sw_chg  = chg_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce with DB_CYCLES=4
module tb_sw_debounce;

  localparam int WIDTH = 3;
  localparam int DBC   = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_db;
  logic             sw_chg;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;

  int n_checks = 0;
  int n_fail   = 0;
  int chg_cnt  = 0;
  int pulse_cnt = 0;
  int chg_base;
  int pulse_base;

  sw_debounce #(
    .WIDTH    (WIDTH),
    .DB_CYCLES(DBC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .sw_db  (sw_db),
    .sw_chg (sw_chg),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sw_chg === 1'b1) chg_cnt++;
    if (sw_rise !== '0 || sw_fall !== '0) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    sw = '0;
    tick(2);
    rst = 1'b1;
    tick(3);
  endtask

  initial begin
    rst = 1'b0;
    sw  = '0;
    #12;
    check("reset_db",   32'(sw_db),   32'h0);
    check("reset_chg",  32'(sw_chg),  32'h0);
    check("reset_rise", 32'(sw_rise), 32'h0);
    check("reset_fall", 32'(sw_fall), 32'h0);
    tick(1);
    rst = 1'b1;
    tick(3);

    // 1: clean step 000 -> 001
    sw = 3'b001;
    tick(6);
    check("t1_db_e6", 32'(sw_db), 32'h0);
    tick(1);
    check("t1_db_e7",   32'(sw_db),   32'h1);
    check("t1_chg_e7",  32'(sw_chg),  32'h1);
    check("t1_rise_e7", 32'(sw_rise), 32'h1);
    check("t1_fall_e7", 32'(sw_fall), 32'h0);
    tick(1);
    check("t1_chg_e8",  32'(sw_chg),  32'h0);
    check("t1_rise_e8", 32'(sw_rise), 32'h0);
    check("t1_db_e8",   32'(sw_db),   32'h1);

    // 2: short glitch from 000
    do_reset();
    check("t2_db_start", 32'(sw_db), 32'h0);
    chg_base = chg_cnt; pulse_base = pulse_cnt;
    sw = 3'b001;
    tick(2);
    sw = 3'b000;
    tick(10);
    check("t2_db",     32'(sw_db),                32'h0);
    check("t2_chg",    32'(chg_cnt - chg_base),   32'h0);
    check("t2_pulses", 32'(pulse_cnt - pulse_base), 32'h0);

    // 3: bounce 011/001 from 001, then hold 011
    sw = 3'b001;
    tick(8);
    check("t3_db_start", 32'(sw_db), 32'h1);
    chg_base = chg_cnt;
    for (int i = 0; i < 6; i++) begin
      sw = (i % 2 == 0) ? 3'b011 : 3'b001;
      tick(1);
    end
    sw = 3'b011;
    tick(6);
    check("t3_db_e6", 32'(sw_db), 32'h1);
    tick(1);
    check("t3_db_e7",   32'(sw_db),   32'h3);
    check("t3_rise_e7", 32'(sw_rise), 32'h2);
    check("t3_fall_e7", 32'(sw_fall), 32'h0);
    tick(3);
    check("t3_one_commit", 32'(chg_cnt - chg_base), 32'h1);

    // 4: multi-bit step 011 -> 110
    sw = 3'b110;
    tick(6);
    check("t4_db_e6", 32'(sw_db), 32'h3);
    tick(1);
    check("t4_db_e7",   32'(sw_db),   32'h6);
    check("t4_rise_e7", 32'(sw_rise), 32'h4);
    check("t4_fall_e7", 32'(sw_fall), 32'h1);
    check("t4_chg_e7",  32'(sw_chg),  32'h1);

    // Asynchronous reset while outputs are non-zero clears them without an edge.
    #2 rst = 1'b0;
    #1;
    check("rst_async_db",   32'(sw_db),   32'h0);
    check("rst_async_chg",  32'(sw_chg),  32'h0);
    check("rst_async_rise", 32'(sw_rise), 32'h0);
    check("rst_async_fall", 32'(sw_fall), 32'h0);
    sw = '0;
    tick(2);
    rst = 1'b1;
    tick(3);

    // 5: reset mid-settling on 000 -> 111
    chg_base = chg_cnt;
    sw = 3'b111;
    tick(5);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_db",   32'(sw_db),   32'h0);
    check("t5_rst_chg",  32'(sw_chg),  32'h0);
    check("t5_rst_rise", 32'(sw_rise), 32'h0);
    tick(2);
    rst = 1'b1;
    tick(6);
    check("t5_db_e6", 32'(sw_db), 32'h0);
    tick(1);
    check("t5_db_e7",   32'(sw_db),   32'h7);
    check("t5_rise_e7", 32'(sw_rise), 32'h7);
    tick(1);
    check("t5_one_commit", 32'(chg_cnt - chg_base), 32'h1);

    // 6: candidate 001 replaced by 011 before it matures
    do_reset();
    chg_base = chg_cnt;
    sw = 3'b001;
    tick(3);
    sw = 3'b011;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("t6_db_hold", 32'(sw_db), 32'h0);
    end
    tick(1);
    check("t6_db_e7",   32'(sw_db),   32'h3);
    check("t6_rise_e7", 32'(sw_rise), 32'h3);
    tick(4);
    check("t6_one_commit", 32'(chg_cnt - chg_base), 32'h1);
    check("t6_db_final",   32'(sw_db),              32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
